// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants for the ECC result deserializer
// Purpose: default coordinate width, channel encoding and error-bit indices.
// Ports: none (package).
package ecc_pkg;
    localparam int   DEF_BIT   = 32;
    localparam logic CH_MP     = 1'b0;
    localparam logic CH_MNP    = 1'b1;
    localparam int   ERR_OVR   = 0;
    localparam int   ERR_TRUNC = 1;
endpackage

// File: rtl/ecc_bit_deser.sv
// rtl/ecc_bit_deser.sv - one serial channel: shifter, bit counter, holding buffer
// Purpose: assembles MSB-first x/y bit streams into BIT-wide words and keeps one
//          completed word pending until the top level takes it.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_valid         frame strobe; i_x/i_y sampled while high
//   i_take          the pending word is moved to the output slot on this edge
//   o_pending       holding buffer holds an undelivered word
//   o_x, o_y        holding buffer contents
//   o_ovr           a word completes into a full, non-draining buffer (pulse)
//   o_trunc         strobe dropped mid-frame (pulse)
module ecc_bit_deser
    import ecc_pkg::*;
#(
    parameter int BIT = DEF_BIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic           i_x,
    input  logic           i_y,
    input  logic           i_take,
    output logic           o_pending,
    output logic [BIT-1:0] o_x,
    output logic [BIT-1:0] o_y,
    output logic           o_ovr,
    output logic           o_trunc
);
    localparam int CW = (BIT > 1) ? $clog2(BIT) : 1;

    logic [CW-1:0]  r_cnt;
    logic [BIT-1:0] r_sx;
    logic [BIT-1:0] r_sy;
    logic [BIT-1:0] r_hx;
    logic [BIT-1:0] r_hy;
    logic           r_pend;

    logic           w_last;
    logic           w_done;
    logic           w_accept;
    logic [BIT-1:0] w_wx;
    logic [BIT-1:0] w_wy;

    assign w_last   = (r_cnt == CW'(BIT - 1));
    assign w_done   = i_valid && w_last;
    // Buffer freed on this edge may take the completing word.
    assign w_accept = w_done && (!r_pend || i_take);
    assign w_wx     = {r_sx[BIT-2:0], i_x};
    assign w_wy     = {r_sy[BIT-2:0], i_y};

    assign o_ovr     = w_done && r_pend && !i_take;
    // A non-zero count implies the previous cycle was valid, so this is a falling strobe.
    assign o_trunc   = !i_valid && (r_cnt != '0);
    assign o_pending = r_pend;
    assign o_x       = r_hx;
    assign o_y       = r_hy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_hx   <= '0;
            r_hy   <= '0;
            r_pend <= 1'b0;
        end else begin
            if (i_valid) begin
                r_sx  <= w_wx;
                r_sy  <= w_wy;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end else if (r_cnt != '0) begin
                r_cnt <= '0;
                r_sx  <= '0;
                r_sy  <= '0;
            end

            if (w_accept) begin
                r_hx   <= w_wx;
                r_hy   <= w_wy;
                r_pend <= 1'b1;
            end else if (i_take) begin
                r_pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ecc_result_deser.sv
// rtl/ecc_result_deser.sv - collects mP/mnP serial results into a parallel valid/ready stream
// Purpose: two channel deserializers feed a fixed-priority (mP first) output slot;
//          overrun and truncation events are kept in sticky error flags.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_mP_valid, i_mPx, i_mPy      mP serial frame (MSB first)
//   i_mnP_valid, i_mnPx, i_mnPy   mnP serial frame (MSB first)
//   o_valid, i_ready              output handshake
//   o_sel                         0 = mP, 1 = mnP
//   o_x, o_y                      presented coordinates
//   o_err                         [0] overrun, [1] truncated frame (sticky)
//   i_err_clr                     clears o_err
module ecc_result_deser
    import ecc_pkg::*;
#(
    parameter int BIT = DEF_BIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_mP_valid,
    input  logic           i_mPx,
    input  logic           i_mPy,
    input  logic           i_mnP_valid,
    input  logic           i_mnPx,
    input  logic           i_mnPy,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_sel,
    output logic [BIT-1:0] o_x,
    output logic [BIT-1:0] o_y,
    output logic [1:0]     o_err,
    input  logic           i_err_clr
);
    logic           w_mp_pend;
    logic           w_mnp_pend;
    logic [BIT-1:0] w_mp_x;
    logic [BIT-1:0] w_mp_y;
    logic [BIT-1:0] w_mnp_x;
    logic [BIT-1:0] w_mnp_y;
    logic           w_mp_ovr;
    logic           w_mnp_ovr;
    logic           w_mp_trunc;
    logic           w_mnp_trunc;
    logic           w_free;
    logic           w_take_mp;
    logic           w_take_mnp;
    logic           w_ovr;
    logic           w_trunc;

    logic           r_valid;
    logic           r_sel;
    logic [BIT-1:0] r_x;
    logic [BIT-1:0] r_y;
    logic [1:0]     r_err;

    ecc_bit_deser #(.BIT(BIT)) u_mp (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_mP_valid),
        .i_x       (i_mPx),
        .i_y       (i_mPy),
        .i_take    (w_take_mp),
        .o_pending (w_mp_pend),
        .o_x       (w_mp_x),
        .o_y       (w_mp_y),
        .o_ovr     (w_mp_ovr),
        .o_trunc   (w_mp_trunc)
    );

    ecc_bit_deser #(.BIT(BIT)) u_mnp (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_mnP_valid),
        .i_x       (i_mnPx),
        .i_y       (i_mnPy),
        .i_take    (w_take_mnp),
        .o_pending (w_mnp_pend),
        .o_x       (w_mnp_x),
        .o_y       (w_mnp_y),
        .o_ovr     (w_mnp_ovr),
        .o_trunc   (w_mnp_trunc)
    );

    // Slot can load when empty or when its word leaves on this edge.
    assign w_free     = !r_valid || i_ready;
    assign w_take_mp  = w_free && w_mp_pend;
    assign w_take_mnp = w_free && !w_mp_pend && w_mnp_pend;
    assign w_ovr      = w_mp_ovr || w_mnp_ovr;
    assign w_trunc    = w_mp_trunc || w_mnp_trunc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_sel   <= CH_MP;
            r_x     <= '0;
            r_y     <= '0;
            r_err   <= 2'b00;
        end else begin
            if (w_take_mp) begin
                r_valid <= 1'b1;
                r_sel   <= CH_MP;
                r_x     <= w_mp_x;
                r_y     <= w_mp_y;
            end else if (w_take_mnp) begin
                r_valid <= 1'b1;
                r_sel   <= CH_MNP;
                r_x     <= w_mnp_x;
                r_y     <= w_mnp_y;
            end else if (w_free) begin
                r_valid <= 1'b0;
            end

            // A new event on the clear edge wins, keeping the flag set.
            if (w_ovr)
                r_err[ERR_OVR] <= 1'b1;
            else if (i_err_clr)
                r_err[ERR_OVR] <= 1'b0;

            if (w_trunc)
                r_err[ERR_TRUNC] <= 1'b1;
            else if (i_err_clr)
                r_err[ERR_TRUNC] <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_sel   = r_sel;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_err   = r_err;
endmodule

// File: tb/tb_ecc_result_deser.sv
// tb/tb_ecc_result_deser.sv - scoreboard bench for ecc_result_deser
module tb_ecc_result_deser;
    localparam int BIT = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_mP_valid = 1'b0, i_mPx = 1'b0, i_mPy = 1'b0;
    logic           i_mnP_valid = 1'b0, i_mnPx = 1'b0, i_mnPy = 1'b0;
    logic           i_ready = 1'b1;
    logic           i_err_clr = 1'b0;
    logic           o_valid, o_sel;
    logic [BIT-1:0] o_x, o_y;
    logic [1:0]     o_err;

    always #5 clk = ~clk;

    ecc_result_deser #(.BIT(BIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mP_valid  (i_mP_valid),
        .i_mPx       (i_mPx),
        .i_mPy       (i_mPy),
        .i_mnP_valid (i_mnP_valid),
        .i_mnPx      (i_mnPx),
        .i_mnPy      (i_mnPy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sel       (o_sel),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_err       (o_err),
        .i_err_clr   (i_err_clr)
    );

    logic [63:0] q_mp[$];
    logic [63:0] q_mnp[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives nbits of a frame MSB first; each bit is sampled by the next posedge.
    task automatic drive(input bit ch, input logic [31:0] x, input logic [31:0] y,
                         input int nbits, input bit push);
        if (push) begin
            if (ch) q_mnp.push_back({x, y});
            else    q_mp.push_back({x, y});
        end
        for (int i = 0; i < nbits; i++) begin
            if (ch) begin i_mnP_valid = 1'b1; i_mnPx = x[BIT-1-i]; i_mnPy = y[BIT-1-i]; end
            else    begin i_mP_valid  = 1'b1; i_mPx  = x[BIT-1-i]; i_mPy  = y[BIT-1-i]; end
            @(posedge clk); #1;
        end
        if (ch) i_mnP_valid = 1'b0;
        else    i_mP_valid  = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((q_mp.size() != 0 || q_mnp.size() != 0 || o_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic clr_err();
        i_err_clr = 1'b1;
        step(1);
        i_err_clr = 1'b0;
    endtask

    // Monitor: pops the channel queue named by o_sel on every handshake and
    // checks that a stalled word stays put.
    logic        prev_stall = 1'b0;
    logic [64:0] prev_word  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_hold", {o_sel, o_x, o_y}, prev_word);
            end
            if (o_valid && i_ready) begin
                if (o_sel) begin
                    chk("mnp_expected", q_mnp.size() != 0, 1);
                    if (q_mnp.size() != 0) chk("mnp_word", {o_x, o_y}, q_mnp.pop_front());
                end else begin
                    chk("mp_expected", q_mp.size() != 0, 1);
                    if (q_mp.size() != 0) chk("mp_word", {o_x, o_y}, q_mp.pop_front());
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_word  = {o_sel, o_x, o_y};
        end
    end

    bit done_mp = 1'b0;
    bit done_mnp = 1'b0;

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_xy", {o_x, o_y}, 0);
        chk("rst_err", o_err, 0);
        step(3);
        rst = 1'b1;
        step(1);

        // Single frame
        drive(0, 32'h1234_5678, 32'h9ABC_DEF0, BIT, 1);
        @(negedge clk); chk("t1_not_yet", o_valid, 0);
        @(negedge clk); chk("t1_valid", o_valid, 1); chk("t1_sel", o_sel, 0);
        chk("t1_x", o_x, 32'h1234_5678); chk("t1_y", o_y, 32'h9ABC_DEF0);
        @(negedge clk); chk("t1_one_cycle", o_valid, 0); chk("t1_err", o_err, 0);
        step(1);

        // Back-to-back with long stall
        i_ready = 1'b0;
        fork
            drive(0, $urandom, $urandom, BIT, 1);
            begin step(5); drive(1, 32'hDEAD_BEEF, 32'h0000_0001, BIT, 1); end
        join
        step(100);
        i_ready = 1'b1;
        @(negedge clk); chk("t2_first_valid", o_valid, 1); chk("t2_first_sel", o_sel, 0);
        @(negedge clk); chk("t2_second_valid", o_valid, 1); chk("t2_second_sel", o_sel, 1);
        chk("t2_second_x", o_x, 32'hDEAD_BEEF);
        @(negedge clk); chk("t2_done", o_valid, 0); chk("t2_err", o_err, 0);
        step(1);

        // Simultaneous completion
        fork
            drive(0, $urandom, $urandom, BIT, 1);
            drive(1, $urandom, $urandom, BIT, 1);
        join
        @(negedge clk); chk("t3_not_yet", o_valid, 0);
        @(negedge clk); chk("t3_first_sel", {o_valid, o_sel}, 2'b10);
        @(negedge clk); chk("t3_second_sel", {o_valid, o_sel}, 2'b11);
        @(negedge clk); chk("t3_done", o_valid, 0);
        step(1);

        // Overrun: C is dropped
        i_ready = 1'b0;
        drive(0, $urandom, $urandom, BIT, 1);
        drive(0, $urandom, $urandom, BIT, 1);
        drive(0, $urandom, $urandom, BIT, 0);
        @(negedge clk); chk("t4_ovr_set", o_err, 2'b01);
        step(1);
        i_ready = 1'b1;
        wait_drain("t4_drain", 20);
        chk("t4_ovr_sticky", o_err, 2'b01);
        clr_err();
        @(negedge clk); chk("t4_clr", o_err, 2'b00);
        step(1);

        // Truncation
        drive(1, $urandom, $urandom, 10, 0);
        step(1);
        @(negedge clk); chk("t5_trunc", o_err, 2'b10); chk("t5_no_valid", o_valid, 0);
        step(3);
        chk("t5_still_no_valid", o_valid, 0);
        clr_err();
        drive(1, $urandom, $urandom, BIT, 1);
        wait_drain("t5_drain", 20);
        chk("t5_err_after", o_err, 2'b00);

        // Reset mid-frame with a word stalled in the slot
        i_ready = 1'b0;
        drive(0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, BIT, 0);
        step(2);
        drive(0, $urandom, $urandom, 16, 0);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_xy", {o_x, o_y}, 0);
        chk("t6_rst_sel_err", {o_sel, o_err}, 0);
        step(2);
        rst = 1'b1;
        i_ready = 1'b1;
        step(1);
        drive(0, 32'h0F0F_1234, 32'h8000_0001, BIT, 1);
        wait_drain("t6_drain", 20);
        chk("t6_err", o_err, 0);

        // Randomized traffic on both channels with random back-pressure
        fork
            begin
                for (int k = 0; k < 15; k++) begin
                    step($urandom_range(0, 3));
                    drive(0, $urandom, $urandom, BIT, 1);
                end
                done_mp = 1'b1;
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    step($urandom_range(0, 3));
                    drive(1, $urandom, $urandom, BIT, 1);
                end
                done_mnp = 1'b1;
            end
            begin
                while (!(done_mp && done_mnp)) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    step(1);
                end
            end
        join
        i_ready = 1'b1;
        wait_drain("rand_drain", 100);
        chk("rand_err", o_err, 0);
        chk("queues_empty", q_mp.size() + q_mnp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ecc_result_deser.md
# ecc_result_deser

Bit-serial to parallel collector downstream of the ECC point-multiplier wrapper. It captures the two MSB-first result streams, mP (x,y) and mnP (x,y), into BIT-wide words and buffers one word per channel, because the wrapper has no back-pressure. It presents completed results to a parallel consumer over a valid/ready handshake. Protocol violations on the serial side are flagged in sticky error bits.

## Interface
- BIT, 32, width of each coordinate word; also the number of bits per serial frame.
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- i_mP_valid  in  1  mP frame strobe; high for exactly BIT consecutive cycles per word.
- i_mPx, i_mPy  in  1 each  mP x/y bits, MSB first, sampled while i_mP_valid=1.
- i_mnP_valid  in  1  mnP frame strobe, same rules as i_mP_valid.
- i_mnPx, i_mnPy  in  1 each  mnP x/y bits, MSB first.
- o_valid  out  1  result word available.
- i_ready  in  1  consumer accepts; transfer occurs when o_valid && i_ready at posedge.
- o_sel  out  1  source of the presented word: 0 = mP, 1 = mnP.
- o_x, o_y  out  BIT each  presented coordinates.
- o_err  out  2  sticky flags: [0] overrun (word lost), [1] truncated frame.
- i_err_clr  in  1  synchronous pulse that clears o_err.

## Operation
- Each channel has:
  - a shift register pair (x,y);
  - a bit counter, 0..BIT-1;
  - a one-entry holding buffer with a pending flag.
- Shifting: on each posedge with valid=1, shift the new bit in at the LSB and increment the counter.
- Word completion: when the counter is BIT-1 and valid=1, the word is complete.
  - The assembled word, including the current bit, is written to the holding buffer and pending is set.
  - The counter wraps to 0.
  - If valid stays high, the next cycle starts a new frame.
- Truncated frame: valid falling while the counter is in 1..BIT-1.
  - Discard the partial word, reset the counter to 0, set o_err[1].
  - No output results.
- Overrun: a word completes while the holding buffer is still pending and is not being moved out on the same edge.
  - Drop the new word, keep the buffered one, set o_err[0].
- Output slot: one registered slot drives o_sel, o_x, o_y and o_valid.
  - The slot loads when it is empty or being drained this edge (o_valid && i_ready).
  - Source is the pending holding buffer; if both channels are pending, mP wins (fixed priority).
  - The chosen buffer's pending flag clears on the same edge.
- A holding buffer freed on an edge may accept a word completing on that same edge; this is not an overrun.
- Stalling: while o_valid && !i_ready, o_sel/o_x/o_y are held stable.
- Error flags: i_err_clr clears o_err. A new error on the same edge as i_err_clr takes priority, so the flag stays set.

## Timing
- Reset (rst=0, asynchronous), all cleared:
  - counters=0, pending=0, shift registers=0;
  - o_valid=0, o_sel=0, o_x=0, o_y=0, o_err=2'b00.
- Any partial frame is discarded. The first valid after rst deasserts starts bit MSB.
- Latency: last bit sampled at edge N → holding buffer at N → o_valid=1 after edge N+1, when the slot is free.
- Throughput: one word per cycle on the output side.
- Serially, each channel needs BIT cycles per word. With i_ready=1 the block never overruns.
- Worst-case buffering before overrun:
  - per channel: 1 holding entry;
  - shared across channels: 1 output-slot entry.

## Structure
- Package ecc_pkg holds:
  - BIT default (32);
  - channel encoding constants CH_MP=1'b0, CH_MNP=1'b1;
  - error bit indices ERR_OVR=0, ERR_TRUNC=1.
- Sub-module ecc_bit_deser contains the per-channel shifter, counter, holding buffer, pending flag, and overrun/truncation detection. It is instantiated twice, for mP and mnP.
- The top level contains the priority arbiter, the output slot and the error register.

## Test plan
- Single frame, i_ready=1:
  - mP frame x=32'h1234_5678, y=32'h9ABC_DEF0 → o_valid for exactly 1 cycle, one cycle after the last-bit edge, with o_sel=0 and exact values;
  - o_err=0.
- Back-to-back with stall:
  - mP frame, then mnP frame 5 cycles later (x=32'hDEAD_BEEF, y=32'h0000_0001); hold i_ready=0 for 100 cycles, then raise it;
  - → mP word held stable throughout, then mnP word on the next cycle;
  - no error.
- Simultaneous completion:
  - both channels finish on the same edge → mP presented first, mnP immediately after the handshake.
- Overrun:
  - i_ready=0; three consecutive mP frames (A, B, C) → o_err[0]=1;
  - after raising i_ready, A then B are delivered and C is lost;
  - i_err_clr → o_err=0.
- Truncation:
  - i_mnP_valid high for 10 cycles, then low → o_err[1]=1, no o_valid;
  - the next full frame is delivered correctly.
- Reset mid-frame:
  - assert rst after 16 bits of an mP frame → all outputs 0 immediately;
  - after release, a fresh full frame is delivered correctly.
